calc_entry_ctrl: RTL and testbench

Operand-entry and sequencing controller for the calc7 calculator datapath. Collects keypad digit, sign and operator keys into two sign-magnitude BCD operands: bit 20 is the sign, bits 19:0 are five BCD digits with the most significant digit in the upper nibble. Launches the BCD-to-binary converter/ALU with a start pulse, waits for its done, then holds the result display state. Sits between the keypad decoder and the BCD-to-binary conversion stage.

---
 rtl/calc_entry_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_calc_entry_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_ctrl.sv
// Operand-entry and sequencing controller for the calc7 datapath: builds two sign-magnitude
// BCD operands from keypad strokes and launches the converter/ALU. Optional watchdog: CALC_TIMEOUT_EN.
module calc_entry_ctrl #(
    parameter int DIGITS = 5
`ifdef CALC_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              calc_done,
    output logic [4*DIGITS:0] bcd_a,
    output logic [4*DIGITS:0] bcd_b,
    output logic [1:0]        op,
    output logic              calc_start,
    output logic              busy,
    output logic [4*DIGITS:0] disp_bcd,
    output logic              digit_ovf,
    output logic              err_timeout
);

    localparam int W  = 4*DIGITS + 1;
    localparam int MW = 4*DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {S_A, S_B, S_RUN, S_SHOW} state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    a_reg, a_next;
    logic [W-1:0]    b_reg, b_next;
    logic [1:0]      op_reg, op_next;
    logic [CW-1:0]   cnt_a_reg, cnt_a_next;
    logic [CW-1:0]   cnt_b_reg, cnt_b_next;
    logic            ovf_reg, ovf_next;
    logic            start_reg, start_next;

`ifdef CALC_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    logic [WDW-1:0]  wdog_reg, wdog_next;
    logic            tmo_reg, tmo_next;
`endif

    // Key decode
    logic       is_digit, is_sign, is_op, is_eq, is_clr;
    logic [3:0] op_sub;
    logic [1:0] key_op;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_sign  = key_valid && (key_code == 4'd10);
    assign is_op    = key_valid && (key_code >= 4'd11) && (key_code <= 4'd13);
    assign is_eq    = key_valid && (key_code == 4'd14);
    assign is_clr   = key_valid && (key_code == 4'd15);
    assign op_sub   = key_code - 4'd11;
    assign key_op   = op_sub[1:0];

    // Shared digit-entry path for whichever operand is being edited
    logic [W-1:0]  cur_val;
    logic [CW-1:0] cur_cnt;
    logic          leading_zero, op_full;
    logic [W-1:0]  edit_val;
    logic [CW-1:0] edit_cnt;

    assign cur_val      = (state_reg == S_B) ? b_reg : a_reg;
    assign cur_cnt      = (state_reg == S_B) ? cnt_b_reg : cnt_a_reg;
    assign leading_zero = (cur_val[MW-1:0] == '0) && (key_code == 4'd0);
    assign op_full      = (cur_cnt == CW'(DIGITS));
    assign edit_val     = {cur_val[W-1], cur_val[MW-5:0], key_code};
    assign edit_cnt     = cur_cnt + CW'(1);

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        cnt_a_next = cnt_a_reg;
        cnt_b_next = cnt_b_reg;
        ovf_next   = ovf_reg;
        start_next = 1'b0;
`ifdef CALC_TIMEOUT_EN
        wdog_next  = wdog_reg;
        tmo_next   = tmo_reg;
`endif
        if (is_clr) begin
            state_next = S_A;
            a_next     = '0;
            b_next     = '0;
            op_next    = 2'b00;
            cnt_a_next = '0;
            cnt_b_next = '0;
            ovf_next   = 1'b0;
`ifdef CALC_TIMEOUT_EN
            wdog_next  = '0;
            tmo_next   = 1'b0;
`endif
        end else begin
            case (state_reg)
                S_A: begin
                    if (is_digit && !leading_zero) begin
                        if (op_full) begin
                            ovf_next = 1'b1;
                        end else begin
                            a_next     = edit_val;
                            cnt_a_next = edit_cnt;
                        end
                    end else if (is_sign) begin
                        a_next[W-1] = ~a_reg[W-1];
                    end else if (is_op) begin
                        op_next    = key_op;
                        state_next = S_B;
                    end
                end
                S_B: begin
                    if (is_digit && !leading_zero) begin
                        if (op_full) begin
                            ovf_next = 1'b1;
                        end else begin
                            b_next     = edit_val;
                            cnt_b_next = edit_cnt;
                        end
                    end else if (is_sign) begin
                        b_next[W-1] = ~b_reg[W-1];
                    end else if (is_op && (cnt_b_reg == '0)) begin
                        op_next = key_op;
                    end else if (is_eq) begin
                        start_next = 1'b1;
                        state_next = S_RUN;
`ifdef CALC_TIMEOUT_EN
                        wdog_next  = '0;
`endif
                    end
                end
                S_RUN: begin
                    if (calc_done) begin
                        state_next = S_SHOW;
`ifdef CALC_TIMEOUT_EN
                    end else if (wdog_reg == WDW'(TIMEOUT_CYC - 1)) begin
                        state_next = S_SHOW;
                        tmo_next   = 1'b1;
                    end else begin
                        wdog_next = wdog_reg + WDW'(1);
`endif
                    end
                end
                S_SHOW: begin
                    // A fresh digit starts a new calculation with that digit already entered
                    if (is_digit) begin
                        a_next     = {{(W-4){1'b0}}, key_code};
                        b_next     = '0;
                        op_next    = 2'b00;
                        cnt_a_next = (key_code != 4'd0) ? CW'(1) : '0;
                        cnt_b_next = '0;
                        state_next = S_A;
                    end
                end
                default: state_next = S_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_A;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= 2'b00;
            cnt_a_reg <= '0;
            cnt_b_reg <= '0;
            ovf_reg   <= 1'b0;
            start_reg <= 1'b0;
`ifdef CALC_TIMEOUT_EN
            wdog_reg  <= '0;
            tmo_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            op_reg    <= op_next;
            cnt_a_reg <= cnt_a_next;
            cnt_b_reg <= cnt_b_next;
            ovf_reg   <= ovf_next;
            start_reg <= start_next;
`ifdef CALC_TIMEOUT_EN
            wdog_reg  <= wdog_next;
            tmo_reg   <= tmo_next;
`endif
        end
    end

    assign bcd_a      = a_reg;
    assign bcd_b      = b_reg;
    assign op         = op_reg;
    assign calc_start = start_reg;
    assign busy       = (state_reg == S_RUN);
    assign disp_bcd   = ((state_reg == S_A) || (state_reg == S_SHOW)) ? a_reg : b_reg;
    assign digit_ovf  = ovf_reg;
`ifdef CALC_TIMEOUT_EN
    assign err_timeout = tmo_reg;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Scoreboard bench for calc_entry_ctrl: directed key sequences followed by random keys,
// all compared against a decimal-arithmetic model of the calculator entry rules.
module tb_calc_entry_ctrl;

    localparam int DIGITS = 5;
    localparam int W      = 4*DIGITS + 1;
`ifdef CALC_TIMEOUT_EN
    localparam int TO = 1024;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic [3:0]   key_code = 4'd0;
    logic         calc_done = 1'b0;
    logic [W-1:0] bcd_a, bcd_b, disp_bcd;
    logic [1:0]   op;
    logic         calc_start, busy, digit_ovf, err_timeout;

    calc_entry_ctrl #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .calc_done(calc_done), .bcd_a(bcd_a), .bcd_b(bcd_b), .op(op),
        .calc_start(calc_start), .busy(busy), .disp_bcd(disp_bcd),
        .digit_ovf(digit_ovf), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]  due;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic         start;
        logic         busy;
        logic [W-1:0] disp;
        logic         ovf;
        logic         tmo;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: operands as decimal magnitudes plus digit counts
    int          m_mode;   // 0 edit A, 1 edit B, 2 running, 3 showing result
    int unsigned m_amag, m_bmag;
    int          m_acnt, m_bcnt, m_run;
    bit          m_asgn, m_bsgn, m_ovf, m_tmo, m_start;
    bit [1:0]    m_op;

    function automatic logic [W-1:0] to_bcd(input bit sgn, input int unsigned mag);
        logic [W-1:0] r;
        int unsigned  v;
        r = '0;
        v = mag;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        r[W-1] = sgn;
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_amag = 0; m_bmag = 0; m_acnt = 0; m_bcnt = 0; m_run = 0;
        m_asgn = 0; m_bsgn = 0; m_ovf = 0; m_tmo = 0; m_start = 0; m_op = 0;
    endtask

    task automatic enter_digit(inout int unsigned mag, inout int cnt, input int d);
        if (mag == 0 && d == 0) return;
        if (cnt == DIGITS) m_ovf = 1;
        else begin
            mag = mag * 10 + d;
            cnt++;
        end
    endtask

    task automatic model_step(input bit kv, input int code, input bit done, input bit rstn);
        m_start = 0;
        if (!rstn || (kv && code == 15)) begin
            model_reset();
            return;
        end
        case (m_mode)
            0, 1: if (kv) begin
                if (code <= 9) begin
                    if (m_mode == 0) enter_digit(m_amag, m_acnt, code);
                    else             enter_digit(m_bmag, m_bcnt, code);
                end else if (code == 10) begin
                    if (m_mode == 0) m_asgn = !m_asgn; else m_bsgn = !m_bsgn;
                end else if (code >= 11 && code <= 13) begin
                    if (m_mode == 0) begin
                        m_op = 2'(code - 11);
                        m_mode = 1;
                    end else if (m_bcnt == 0) m_op = 2'(code - 11);
                end else if (code == 14 && m_mode == 1) begin
                    m_start = 1;
                    m_mode = 2;
                    m_run = 0;
                end
            end
            2: begin
                if (done) m_mode = 3;
                else begin
                    m_run++;
`ifdef CALC_TIMEOUT_EN
                    if (m_run == TO) begin
                        m_mode = 3;
                        m_tmo = 1;
                    end
`endif
                end
            end
            default: if (kv && code <= 9) begin
                m_amag = code; m_acnt = (code != 0) ? 1 : 0; m_asgn = 0;
                m_bmag = 0; m_bcnt = 0; m_bsgn = 0; m_op = 0; m_mode = 0;
            end
        endcase
    endtask

    // Applies one cycle of inputs (called just after a rising edge) and queues the expectation
    task automatic step(input bit kv, input int code, input bit done, input bit rstn);
        exp_t e;
        key_valid = kv;
        key_code  = 4'(code);
        calc_done = done;
        rst_n     = rstn;
        model_step(kv, code, done, rstn);
        e.due   = cyc + 1;
        e.a     = to_bcd(m_asgn, m_amag);
        e.b     = to_bcd(m_bsgn, m_bmag);
        e.op    = m_op;
        e.start = m_start;
        e.busy  = (m_mode == 2);
        e.disp  = (m_mode == 0 || m_mode == 3) ? e.a : e.b;
        e.ovf   = m_ovf;
        e.tmo   = m_tmo;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        key_valid = 0;
        calc_done = 0;
        rst_n     = 1;
    endtask

    task automatic key(input int code);
        step(1, code, 0, 1);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            $display("cyc %0d a=%h b=%h op=%0d start=%b busy=%b disp=%h ovf=%b tmo=%b",
                     cyc, bcd_a, bcd_b, op, calc_start, busy, disp_bcd, digit_ovf, err_timeout);
            if (bcd_a !== e.a || bcd_b !== e.b || op !== e.op || calc_start !== e.start ||
                busy !== e.busy || disp_bcd !== e.disp || digit_ovf !== e.ovf ||
                err_timeout !== e.tmo) begin
                n_fail++;
                $display("FAIL snapshot cyc %0d: got a=%h b=%h op=%0d st=%b busy=%b disp=%h ovf=%b tmo=%b expected a=%h b=%h op=%0d st=%b busy=%b disp=%h ovf=%b tmo=%b",
                         cyc, bcd_a, bcd_b, op, calc_start, busy, disp_bcd, digit_ovf, err_timeout,
                         e.a, e.b, e.op, e.start, e.busy, e.disp, e.ovf, e.tmo);
            end
        end
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        step(0, 0, 0, 0);
        check("reset_a", 32'(bcd_a), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);

        // 123, sign, add, 45, equals
        key(1); key(2); key(3); key(10); key(11); key(4); key(5); key(14);
        check("start_pulse", 32'(calc_start), 32'h1);
        step(0, 0, 0, 1);
        check("start_once", 32'(calc_start), 32'h0);
        check("run_busy", 32'(busy), 32'h1);
        check("op_a", 32'(bcd_a), 32'h100123);
        check("op_b", 32'(bcd_b), 32'h000045);
        check("op_add", 32'(op), 32'h0);
        step(0, 0, 1, 1);
        check("show_busy", 32'(busy), 32'h0);
        key(8);
        check("show_digit_a", 32'(bcd_a), 32'h000008);
        check("show_digit_b", 32'(bcd_b), 32'h0);

        // Leading zeros and overflow
        key(15); key(0); key(0); key(7);
        check("lead_zero", 32'(bcd_a), 32'h000007);
        key(1); key(2); key(3); key(4); key(5);
        check("ovf_a", 32'(bcd_a), 32'h071234);
        check("ovf_flag", 32'(digit_ovf), 32'h1);
        key(15);
        check("clear_a", 32'(bcd_a), 32'h0);
        check("clear_ovf", 32'(digit_ovf), 32'h0);

        // Equals ignored in S_A, op replacement only while B empty
        key(14);
        check("eq_in_a", 32'(calc_start), 32'h0);
        key(9); key(11); key(12); key(13); key(3);
        check("op_mul", 32'(op), 32'h2);
        check("b_three", 32'(bcd_b), 32'h000003);
        key(11);
        check("op_locked", 32'(op), 32'h2);

        // Clear wins over calc_done
        key(14);
        step(1, 15, 1, 1);
        check("clr_done_busy", 32'(busy), 32'h0);
        check("clr_done_a", 32'(bcd_a), 32'h0);
        key(4);
        check("clr_done_edit", 32'(disp_bcd), 32'h000004);

        // Reset mid-run, late calc_done ignored
        key(11); key(2); key(14); step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 1, 1);
        check("rst_run_busy", 32'(busy), 32'h0);
        check("rst_run_a", 32'(bcd_a), 32'h0);

        // Long wait in S_RUN
        key(6); key(12); key(1); key(14);
`ifdef CALC_TIMEOUT_EN
        for (int i = 0; i < TO + 4; i++) step(0, 0, 0, 1);
        check("timeout_flag", 32'(err_timeout), 32'h1);
        check("timeout_busy", 32'(busy), 32'h0);
`else
        for (int i = 0; i < 110; i++) step(0, 0, 0, 1);
        check("wait_busy", 32'(busy), 32'h1);
`endif
        key(15);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit kv;
            int code;
            r = $urandom_range(0, 99);
            kv = 1;
            if (r < 55)      code = $urandom_range(0, 9);
            else if (r < 62) code = 10;
            else if (r < 75) code = $urandom_range(11, 13);
            else if (r < 85) code = 14;
            else if (r < 87) code = 15;
            else begin
                kv = 0;
                code = $urandom_range(0, 15);
            end
            step(kv, code, $urandom_range(0, 9) == 0, $urandom_range(0, 199) != 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
